writeback_arbiter: RTL and testbench



---
 rtl/writeback_arbiter.sv | 166 ++++++++++++++++
 tb/tb_writeback_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: round-robin selection of up to two finished execution-unit
// results per cycle onto the register file's two write ports, with busy-bit release.
module writeback_arbiter #(
   parameter int DATA_W = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              alu1_done,
   input  logic [5:0]        alu1_rd_rn,
   input  logic [DATA_W-1:0] alu1_rd_data,
   input  logic              alu2_done,
   input  logic [5:0]        alu2_rd_rn,
   input  logic [DATA_W-1:0] alu2_rd_data,
   input  logic              advint_done,
   input  logic [5:0]        advint_rd_rn,
   input  logic [DATA_W-1:0] advint_rd_data,
   input  logic [5:0]        advint_rd2_rn,
   input  logic [DATA_W-1:0] advint_rd2_data,
   input  logic              memunit_done,
   input  logic [5:0]        memunit_rd_rn,
   input  logic [DATA_W-1:0] memunit_rd_data,
   input  logic              branch_done,
   input  logic [5:0]        branch_rd_rn,
   input  logic [DATA_W-1:0] branch_rd_data,
   output logic              alu1_ack,
   output logic              alu2_ack,
   output logic              advint_ack,
   output logic              memunit_ack,
   output logic              branch_ack,
   output logic              wr1_en,
   output logic [5:0]        wr1_rn,
   output logic [DATA_W-1:0] wr1_data,
   output logic              wr2_en,
   output logic [5:0]        wr2_rn,
   output logic [DATA_W-1:0] wr2_data,
   output logic [5:0]        reg1_finished,
   output logic [5:0]        reg2_finished
);
   localparam int N = 5;

   logic              done_v [N];
   logic [5:0]        rn_v   [N];
   logic [DATA_W-1:0] data_v [N];
   logic              adv_two;

   logic [2:0]        ptr_q, ptr_d;
   logic [4:0]        ack_q, ack_d;
   logic              wr1_en_q, wr1_en_d, wr2_en_q, wr2_en_d;
   logic [5:0]        wr1_rn_q, wr1_rn_d, wr2_rn_q, wr2_rn_d;
   logic [DATA_W-1:0] wr1_data_q, wr1_data_d, wr2_data_q, wr2_data_d;

   logic [3:0]        sum;
   logic [2:0]        idx;
   logic              p1_used, p2_used, stop, hit;

   // A single-write advint uses rd when present, otherwise rd2; equal rns collapse to rd.
   always_comb begin
      done_v[0] = alu1_done;    rn_v[0] = alu1_rd_rn;    data_v[0] = alu1_rd_data;
      done_v[1] = alu2_done;    rn_v[1] = alu2_rd_rn;    data_v[1] = alu2_rd_data;
      done_v[2] = advint_done;
      rn_v[2]   = (advint_rd_rn != 6'd0) ? advint_rd_rn   : advint_rd2_rn;
      data_v[2] = (advint_rd_rn != 6'd0) ? advint_rd_data : advint_rd2_data;
      done_v[3] = memunit_done; rn_v[3] = memunit_rd_rn; data_v[3] = memunit_rd_data;
      done_v[4] = branch_done;  rn_v[4] = branch_rd_rn;  data_v[4] = branch_rd_data;
   end

   assign adv_two = (advint_rd_rn != 6'd0) && (advint_rd2_rn != 6'd0) &&
                    (advint_rd_rn != advint_rd2_rn);

   // Sources acked last cycle (ack_q) are masked: the unit only drops done after this edge.
   always_comb begin
      ptr_d      = ptr_q;
      ack_d      = 5'd0;
      wr1_en_d   = 1'b0;
      wr1_rn_d   = 6'd0;
      wr1_data_d = '0;
      wr2_en_d   = 1'b0;
      wr2_rn_d   = 6'd0;
      wr2_data_d = '0;
      p1_used    = 1'b0;
      p2_used    = 1'b0;
      stop       = 1'b0;
      hit        = 1'b0;
      sum        = 4'd0;
      idx        = 3'd0;
      for (int k = 0; k < N; k++) begin
         sum = {1'b0, ptr_q} + 4'(k);
         if (sum > 4'd4) sum = sum - 4'd5;
         idx = sum[2:0];
         hit = 1'b0;
         if (!stop && done_v[idx] && !ack_q[idx]) begin
            if (idx == 3'd2 && adv_two) begin
               if (!p1_used) begin
                  wr1_en_d   = 1'b1;
                  wr1_rn_d   = advint_rd_rn;
                  wr1_data_d = advint_rd_data;
                  wr2_en_d   = 1'b1;
                  wr2_rn_d   = advint_rd2_rn;
                  wr2_data_d = advint_rd2_data;
                  p1_used    = 1'b1;
                  p2_used    = 1'b1;
                  stop       = 1'b1;
                  hit        = 1'b1;
               end
            end else if (rn_v[idx] == 6'd0) begin
               hit = 1'b1;
            end else if (!p1_used) begin
               wr1_en_d   = 1'b1;
               wr1_rn_d   = rn_v[idx];
               wr1_data_d = data_v[idx];
               p1_used    = 1'b1;
               hit        = 1'b1;
            end else if (!p2_used && rn_v[idx] != wr1_rn_d) begin
               wr2_en_d   = 1'b1;
               wr2_rn_d   = rn_v[idx];
               wr2_data_d = data_v[idx];
               p2_used    = 1'b1;
               hit        = 1'b1;
            end
         end
         if (hit) begin
            ack_d[idx] = 1'b1;
            ptr_d      = (idx == 3'd4) ? 3'd0 : idx + 3'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q      <= 3'd0;
         ack_q      <= 5'd0;
         wr1_en_q   <= 1'b0;
         wr1_rn_q   <= 6'd0;
         wr1_data_q <= '0;
         wr2_en_q   <= 1'b0;
         wr2_rn_q   <= 6'd0;
         wr2_data_q <= '0;
      end else begin
         ptr_q      <= ptr_d;
         ack_q      <= ack_d;
         wr1_en_q   <= wr1_en_d;
         wr1_rn_q   <= wr1_rn_d;
         wr1_data_q <= wr1_data_d;
         wr2_en_q   <= wr2_en_d;
         wr2_rn_q   <= wr2_rn_d;
         wr2_data_q <= wr2_data_d;
      end
   end

   assign alu1_ack    = ack_q[0];
   assign alu2_ack    = ack_q[1];
   assign advint_ack  = ack_q[2];
   assign memunit_ack = ack_q[3];
   assign branch_ack  = ack_q[4];

   assign wr1_en   = wr1_en_q;
   assign wr1_rn   = wr1_rn_q;
   assign wr1_data = wr1_data_q;
   assign wr2_en   = wr2_en_q;
   assign wr2_rn   = wr2_rn_q;
   assign wr2_data = wr2_data_q;

   // rn registers are zero whenever the matching enable is low.
   assign reg1_finished = wr1_rn_q;
   assign reg2_finished = wr2_rn_q;
endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: directed scenarios plus randomized unit traffic,
// checked against a list-based reference model of the arbitration rules.
module tb_writeback_arbiter;
   localparam int DW = 64;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          u_done [5];
   logic [5:0]    u_rn   [5];
   logic [DW-1:0] u_data [5];
   logic [5:0]    a_rd2_rn;
   logic [DW-1:0] a_rd2_data;

   logic          d_ack [5];
   logic          d_w1_en, d_w2_en;
   logic [5:0]    d_w1_rn, d_w2_rn, d_f1, d_f2;
   logic [DW-1:0] d_w1_data, d_w2_data;

   logic [4:0]    e_ack;
   logic          e_w1_en, e_w2_en;
   logic [5:0]    e_w1_rn, e_w2_rn;
   logic [DW-1:0] e_w1_data, e_w2_data;
   int            m_ptr;
   logic [4:0]    m_mask;

   int total = 0;
   int bad = 0;

   writeback_arbiter #(.DATA_W(DW)) dut (
      .clk(clk), .rst_n(rst_n),
      .alu1_done(u_done[0]), .alu1_rd_rn(u_rn[0]), .alu1_rd_data(u_data[0]),
      .alu2_done(u_done[1]), .alu2_rd_rn(u_rn[1]), .alu2_rd_data(u_data[1]),
      .advint_done(u_done[2]), .advint_rd_rn(u_rn[2]), .advint_rd_data(u_data[2]),
      .advint_rd2_rn(a_rd2_rn), .advint_rd2_data(a_rd2_data),
      .memunit_done(u_done[3]), .memunit_rd_rn(u_rn[3]), .memunit_rd_data(u_data[3]),
      .branch_done(u_done[4]), .branch_rd_rn(u_rn[4]), .branch_rd_data(u_data[4]),
      .alu1_ack(d_ack[0]), .alu2_ack(d_ack[1]), .advint_ack(d_ack[2]),
      .memunit_ack(d_ack[3]), .branch_ack(d_ack[4]),
      .wr1_en(d_w1_en), .wr1_rn(d_w1_rn), .wr1_data(d_w1_data),
      .wr2_en(d_w2_en), .wr2_rn(d_w2_rn), .wr2_data(d_w2_data),
      .reg1_finished(d_f1), .reg2_finished(d_f2)
   );

   task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [4:0] dut_acks();
      logic [4:0] a;
      for (int i = 0; i < 5; i++) a[i] = d_ack[i];
      return a;
   endfunction

   // Reference: list eligible sources in round-robin order, then hand out ports.
   task automatic predict();
      int order[$];
      int last, used, nw, i;
      logic [5:0] rn;
      logic [DW-1:0] dat;
      logic stop;
      e_ack = '0; e_w1_en = 0; e_w1_rn = 0; e_w1_data = 0;
      e_w2_en = 0; e_w2_rn = 0; e_w2_data = 0;
      last = -1; used = 0; stop = 0;
      for (int k = 0; k < 5; k++) begin
         i = (m_ptr + k) % 5;
         if (u_done[i] && !m_mask[i]) order.push_back(i);
      end
      for (int j = 0; j < order.size(); j++) begin
         i = order[j]; rn = 0; dat = 0; nw = 0;
         if (i == 2) begin
            if (u_rn[2] != 0 && a_rd2_rn != 0 && u_rn[2] != a_rd2_rn) nw = 2;
            else if (u_rn[2] != 0) begin nw = 1; rn = u_rn[2]; dat = u_data[2]; end
            else if (a_rd2_rn != 0) begin nw = 1; rn = a_rd2_rn; dat = a_rd2_data; end
         end else if (u_rn[i] != 0) begin
            nw = 1; rn = u_rn[i]; dat = u_data[i];
         end
         if (stop) begin
         end else if (nw == 2) begin
            if (used == 0) begin
               e_w1_en = 1; e_w1_rn = u_rn[2]; e_w1_data = u_data[2];
               e_w2_en = 1; e_w2_rn = a_rd2_rn; e_w2_data = a_rd2_data;
               e_ack[2] = 1; last = 2; used = 2; stop = 1;
            end
         end else if (nw == 0) begin
            e_ack[i] = 1; last = i;
         end else if (used == 0) begin
            e_w1_en = 1; e_w1_rn = rn; e_w1_data = dat; e_ack[i] = 1; last = i; used = 1;
         end else if (used == 1 && rn != e_w1_rn) begin
            e_w2_en = 1; e_w2_rn = rn; e_w2_data = dat; e_ack[i] = 1; last = i; used = 2;
         end
      end
      if (last >= 0) m_ptr = (last + 1) % 5;
      m_mask = e_ack;
   endtask

   task automatic compare();
      check_eq("ack", 64'(dut_acks()), 64'(e_ack));
      check_eq("wr1_en", 64'(d_w1_en), 64'(e_w1_en));
      check_eq("wr1_rn", 64'(d_w1_rn), 64'(e_w1_rn));
      check_eq("wr1_data", d_w1_data, e_w1_data);
      check_eq("wr2_en", 64'(d_w2_en), 64'(e_w2_en));
      check_eq("wr2_rn", 64'(d_w2_rn), 64'(e_w2_rn));
      check_eq("wr2_data", d_w2_data, e_w2_data);
      check_eq("reg1_finished", 64'(d_f1), 64'(e_w1_en ? e_w1_rn : 6'd0));
      check_eq("reg2_finished", 64'(d_f2), 64'(e_w2_en ? e_w2_rn : 6'd0));
      check_eq("ptr", 64'(dut.ptr_q), 64'(m_ptr));
   endtask

   task automatic step();
      predict();
      @(posedge clk);
      #1;
      compare();
   endtask

   task automatic new_result(input int i);
      u_done[i] = 1'b1;
      u_rn[i]   = 6'($urandom_range(0, 7));
      u_data[i] = {$urandom, $urandom};
      if (i == 2) begin
         a_rd2_rn   = 6'($urandom_range(0, 7));
         a_rd2_data = {$urandom, $urandom};
      end
   endtask

   // Units react to the ack they see at this edge: drop done or present a new result.
   task automatic handshake(input int pct_new);
      for (int i = 0; i < 5; i++)
         if (e_ack[i]) begin
            if (int'($urandom_range(0, 99)) < pct_new) new_result(i);
            else u_done[i] = 1'b0;
         end
   endtask

   task automatic set_unit(input int i, input logic [5:0] rn, input logic [DW-1:0] dat);
      u_done[i] = 1'b1; u_rn[i] = rn; u_data[i] = dat;
   endtask

   task automatic clear_units();
      for (int i = 0; i < 5; i++) begin
         u_done[i] = 0; u_rn[i] = 0; u_data[i] = 0;
      end
      a_rd2_rn = 0; a_rd2_data = 0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      check_eq("rst_ack", 64'(dut_acks()), 64'd0);
      check_eq("rst_wr1", {d_w1_data[DW-8:0], d_w1_rn, d_w1_en}, 64'd0);
      check_eq("rst_wr2", {d_w2_data[DW-8:0], d_w2_rn, d_w2_en}, 64'd0);
      check_eq("rst_fin", 64'({d_f1, d_f2}), 64'd0);
      check_eq("rst_ptr", 64'(dut.ptr_q), 64'd0);
      m_ptr = 0; m_mask = '0; e_ack = '0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      clear_units();
      m_ptr = 0; m_mask = '0; e_ack = '0;
      do_reset();
      step();

      // single alu1 result
      set_unit(0, 6'd5, 64'h1234);
      step();
      check_eq("c1_wr1_rn", 64'(d_w1_rn), 64'd5);
      check_eq("c1_wr1_data", d_w1_data, 64'h1234);
      check_eq("c1_ptr", 64'(dut.ptr_q), 64'd1);
      check_eq("c1_wr2_en", 64'(d_w2_en), 64'd0);
      handshake(0);
      step();

      // all five at once from ptr 0
      clear_units(); do_reset();
      for (int i = 0; i < 5; i++) set_unit(i, 6'(i + 1), 64'(i * 256 + 7));
      step(); check_eq("c2_ack1", 64'(dut_acks()), 64'b00011); handshake(0);
      step(); check_eq("c2_ack2", 64'(dut_acks()), 64'b01100); handshake(0);
      step(); check_eq("c2_ack3", 64'(dut_acks()), 64'b10000); handshake(0);

      // two-write advint first in scan (ptr 2)
      clear_units(); do_reset();
      set_unit(1, 6'd1, 64'h11);
      step(); handshake(0);
      set_unit(2, 6'd7, 64'h77); a_rd2_rn = 6'd9; a_rd2_data = 64'h99;
      set_unit(0, 6'd3, 64'h33);
      step();
      check_eq("c3_wr1_rn", 64'(d_w1_rn), 64'd7);
      check_eq("c3_wr2_rn", 64'(d_w2_rn), 64'd9);
      check_eq("c3_ack", 64'(dut_acks()), 64'b00100);
      handshake(0);
      step();
      check_eq("c3_next", 64'(d_w1_rn), 64'd3);
      handshake(0);

      // same with ptr 0: advint skipped
      clear_units(); do_reset();
      set_unit(2, 6'd7, 64'h77); a_rd2_rn = 6'd9; a_rd2_data = 64'h99;
      set_unit(0, 6'd3, 64'h33);
      step();
      check_eq("c3b_ack", 64'(dut_acks()), 64'b00001);
      check_eq("c3b_wr2_en", 64'(d_w2_en), 64'd0);
      handshake(0); step(); handshake(0);

      // WAW between alu1 and memunit
      clear_units(); do_reset();
      set_unit(0, 6'd12, 64'hA); set_unit(3, 6'd12, 64'hB);
      step();
      check_eq("c4_ack", 64'(dut_acks()), 64'b00001);
      check_eq("c4_fin2", 64'(d_f2), 64'd0);
      handshake(0);
      step();
      check_eq("c4_mem", 64'(dut_acks()), 64'b01000);
      check_eq("c4_mem_data", d_w1_data, 64'hB);
      handshake(0);

      // zero-write branch alongside alu2
      clear_units(); do_reset();
      set_unit(4, 6'd0, 64'h5); set_unit(1, 6'd4, 64'h44);
      step();
      check_eq("c5_ack", 64'(dut_acks()), 64'b10010);
      check_eq("c5_wr1_rn", 64'(d_w1_rn), 64'd4);
      check_eq("c5_wr2_en", 64'(d_w2_en), 64'd0);
      handshake(0);

      // reset during a grant cycle, then re-arbitration from alu1
      clear_units(); do_reset();
      set_unit(0, 6'd21, 64'h21); set_unit(1, 6'd22, 64'h22); set_unit(3, 6'd23, 64'h23);
      step(); step();
      do_reset();
      step();
      check_eq("c6_wr1_rn", 64'(d_w1_rn), 64'd21);
      check_eq("c6_wr2_rn", 64'(d_w2_rn), 64'd22);
      handshake(0);

      // randomized traffic
      clear_units(); do_reset();
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < 5; i++)
            if (!u_done[i] && $urandom_range(0, 99) < 45) new_result(i);
         step();
         handshake(30);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
